vec_bit_serializer: RTL and testbench



---
 rtl/vec_bit_serializer.sv | 149 ++++++++++++++
 tb/tb_vec_bit_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_bit_serializer.sv
// Bit serializer: accepts one WIDTH-bit word per valid/ready handshake and streams it
// one bit per beat, LSB- or MSB-first, with a running popcount and an end-of-word done pulse.
module vec_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int IW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int BW = IW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic [IW-1:0]    out_idx,
    output logic [CW-1:0]    ones_count,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] ONES_MAX  = CW'(WIDTH);
    localparam logic [IW-1:0] TOP_IDX   = IW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [CW-1:0]      ones_q, ones_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               out_bit_q, out_bit_d;
    logic               out_last_q, out_last_d;
    logic [IW-1:0]      out_idx_q, out_idx_d;
    logic               xfer_s;

    // Move the register one place toward the output end, filling with zero.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (LSB_FIRST) begin
            r = {1'b0, v[WIDTH-1:1]};
        end else begin
            r = {v[WIDTH-2:0], 1'b0};
        end
        return r;
    endfunction

    // Handshake sequencing: word capture, beat advance and popcount accumulation.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        beat_d  = beat_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        xfer_s  = out_valid_q & out_ready;
        case (state_q)
            ST_IDLE: begin
                if (in_valid & in_ready_q) begin
                    state_d = ST_SHIFT;
                    sreg_d  = in_data;
                    beat_d  = '0;
                    ones_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (xfer_s) begin
                    sreg_d = advance(sreg_q);
                    ones_d = (ones_q == ONES_MAX) ? ONES_MAX : (ones_q + CW'(out_bit_q));
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sreg_d  = '0;
                beat_d  = '0;
                ones_d  = '0;
            end
        endcase
    end

    // Output values are derived from next state so every port comes straight off a flop.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_SHIFT);
        if (state_d == ST_SHIFT) begin
            out_bit_d  = LSB_FIRST ? sreg_d[0] : sreg_d[WIDTH-1];
            out_idx_d  = LSB_FIRST ? beat_d[IW-1:0] : (TOP_IDX - beat_d[IW-1:0]);
            out_last_d = (beat_d == LAST_BEAT);
        end else begin
            out_bit_d  = 1'b0;
            out_idx_d  = '0;
            out_last_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            beat_q      <= '0;
            ones_q      <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            beat_q      <= beat_d;
            ones_q      <= ones_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_bit    = out_bit_q;
    assign out_last   = out_last_q;
    assign out_idx    = out_idx_q;
    assign ones_count = ones_q;
    assign done       = done_q;

endmodule

// File: tb/tb_vec_bit_serializer.sv
// Randomized bench for vec_bit_serializer: three instances (8/LSB, 7/MSB, 4/LSB) checked
// every cycle against a transaction-level model of the word/beat/popcount rules.
module tb_vec_bit_serializer;

    localparam int WV   [3] = '{8, 7, 4};
    localparam int LSBF [3] = '{1, 0, 1};
    localparam int LIMIT    = 300;

    logic clk;
    logic rst_n;

    logic        iv   [3];
    logic        ordy [3];
    logic [7:0]  id0;
    logic [6:0]  id1;
    logic [3:0]  id2;

    logic        o_rdy  [3];
    logic        o_val  [3];
    logic        o_bit  [3];
    logic        o_last [3];
    logic        o_done [3];
    logic [7:0]  o_idx  [3];
    logic [7:0]  o_ones [3];
    logic [2:0]  idx0, idx1;
    logic [1:0]  idx2;
    logic [3:0]  ones0;
    logic [2:0]  ones1, ones2;

    assign o_idx[0]  = {5'd0, idx0};
    assign o_idx[1]  = {5'd0, idx1};
    assign o_idx[2]  = {6'd0, idx2};
    assign o_ones[0] = {4'd0, ones0};
    assign o_ones[1] = {5'd0, ones1};
    assign o_ones[2] = {5'd0, ones2};

    vec_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(o_rdy[0]), .in_data(id0),
        .out_valid(o_val[0]), .out_ready(ordy[0]), .out_bit(o_bit[0]), .out_last(o_last[0]),
        .out_idx(idx0), .ones_count(ones0), .done(o_done[0]));

    vec_bit_serializer #(.WIDTH(7), .LSB_FIRST(1'b0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(o_rdy[1]), .in_data(id1),
        .out_valid(o_val[1]), .out_ready(ordy[1]), .out_bit(o_bit[1]), .out_last(o_last[1]),
        .out_idx(idx1), .ones_count(ones1), .done(o_done[1]));

    vec_bit_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(o_rdy[2]), .in_data(id2),
        .out_valid(o_val[2]), .out_ready(ordy[2]), .out_bit(o_bit[2]), .out_last(o_last[2]),
        .out_idx(idx2), .ones_count(ones2), .done(o_done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus requested for the next edge, applied at each tick.
    logic        st_v    [3];
    logic        st_r    [3];
    logic [63:0] st_data [3];

    // Reference model: word in flight, beats already transferred, ones so far, done due.
    logic        m_busy [3];
    logic        m_done [3];
    logic [63:0] m_word [3];
    int          m_pos  [3];
    int          m_ones [3];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int src_idx(input int d, input int pos);
        return (LSBF[d] != 0) ? pos : (WV[d] - 1 - pos);
    endfunction

    function automatic int popcount(input int d, input logic [63:0] w);
        int c = 0;
        for (int i = 0; i < WV[d]; i++) c += int'(w[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 1'b0; m_done[d] = 1'b0; m_pos[d] = 0; m_ones[d] = 0; m_word[d] = '0;
        end
    endtask

    task automatic check_reset(input int d);
        check_eq($sformatf("rst_in_ready.d%0d", d), 64'(o_rdy[d]), 64'd1);
        check_eq($sformatf("rst_out_valid.d%0d", d), 64'(o_val[d]), 64'd0);
        check_eq($sformatf("rst_out_bit.d%0d", d), 64'(o_bit[d]), 64'd0);
        check_eq($sformatf("rst_out_last.d%0d", d), 64'(o_last[d]), 64'd0);
        check_eq($sformatf("rst_out_idx.d%0d", d), 64'(o_idx[d]), 64'd0);
        check_eq($sformatf("rst_ones.d%0d", d), 64'(o_ones[d]), 64'd0);
        check_eq($sformatf("rst_done.d%0d", d), 64'(o_done[d]), 64'd0);
    endtask

    // One clock: compare at the falling edge, apply stimulus, advance the model.
    task automatic tick();
        int p;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("in_ready.d%0d", d), 64'(o_rdy[d]), 64'(!m_busy[d]));
            check_eq($sformatf("out_valid.d%0d", d), 64'(o_val[d]), 64'(m_busy[d]));
            check_eq($sformatf("ones_count.d%0d", d), 64'(o_ones[d]), 64'(m_ones[d]));
            check_eq($sformatf("done.d%0d", d), 64'(o_done[d]), 64'(m_done[d]));
            if (m_busy[d]) begin
                p = src_idx(d, m_pos[d]);
                check_eq($sformatf("out_bit.d%0d", d), 64'(o_bit[d]), 64'(m_word[d][p]));
                check_eq($sformatf("out_idx.d%0d", d), 64'(o_idx[d]), 64'(p));
                check_eq($sformatf("out_last.d%0d", d), 64'(o_last[d]),
                         64'(m_pos[d] == WV[d] - 1));
            end else begin
                check_eq($sformatf("idle_last.d%0d", d), 64'(o_last[d]), 64'd0);
            end
            if (m_done[d])
                check_eq($sformatf("popcount.d%0d", d), 64'(o_ones[d]),
                         64'(popcount(d, m_word[d])));
            iv[d]   = st_v[d];
            ordy[d] = st_r[d];
        end
        id0 = st_data[0][7:0];
        id1 = st_data[1][6:0];
        id2 = st_data[2][3:0];
        for (int d = 0; d < 3; d++) begin
            m_done[d] = 1'b0;
            if (!m_busy[d]) begin
                if (st_v[d]) begin
                    m_busy[d] = 1'b1;
                    m_pos[d]  = 0;
                    m_ones[d] = 0;
                    m_word[d] = st_data[d] & ((64'd1 << WV[d]) - 64'd1);
                end
            end else if (st_r[d]) begin
                m_ones[d] += int'(m_word[d][src_idx(d, m_pos[d])]);
                m_pos[d]++;
                if (m_pos[d] == WV[d]) begin
                    m_busy[d] = 1'b0;
                    m_done[d] = 1'b1;
                    m_pos[d]  = 0;
                end
            end
        end
    endtask

    // mode 0: ready held, 1: ready toggling 1,0,..., 2: random ready, 3: in_valid held with new data
    task automatic run_word(input int d, input logic [63:0] data, input int mode);
        int n;
        st_v[d] = 1'b1; st_data[d] = data; st_r[d] = 1'b1;
        tick();
        st_v[d] = (mode == 3);
        n = 0;
        while (m_busy[d] && n < LIMIT) begin
            case (mode)
                1:       st_r[d] = (n % 2 == 0);
                2:       st_r[d] = ($urandom_range(0, 3) != 0);
                default: st_r[d] = 1'b1;
            endcase
            if (mode == 3) st_data[d] = {$urandom, $urandom};
            tick();
            n++;
        end
        check_eq($sformatf("beat_bound.d%0d", d), 64'(n >= LIMIT), 64'd0);
        if (mode == 3) tick();
        st_v[d] = 1'b0; st_r[d] = 1'b1;
        n = 0;
        while (m_busy[d] && n < LIMIT) begin
            tick();
            n++;
        end
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; st_v[d] = 1'b0; st_r[d] = 1'b0; st_data[d] = '0;
        end
        id0 = '0; id1 = '0; id2 = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) check_reset(d);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        run_word(0, 64'hFF, 0);
        run_word(1, 64'h00, 0);
        run_word(0, 64'hA5, 1);
        run_word(0, 64'h3C, 3);
        run_word(2, 64'hF, 0);
        run_word(1, 64'h5B, 1);

        // Asynchronous reset three beats into a word.
        st_v[0] = 1'b1; st_data[0] = 64'hFF; st_r[0] = 1'b1;
        tick();
        st_v[0] = 1'b0;
        repeat (3) tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) check_reset(d);
        @(posedge clk);
        #1;
        check_reset(0);
        #2 rst_n = 1'b1;
        tick();
        run_word(0, 64'h0F, 0);

        for (int k = 0; k < 40; k++)
            run_word($urandom_range(0, 2), {$urandom, $urandom}, $urandom_range(0, 3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
